// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply-divide unit.
package muldiv_pkg;

    // Decoded op codes driven by the controller. Unlisted codes behave as NOP.
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MADD  = 4'd3;
    localparam logic [3:0] OP_MADDU = 4'd4;
    localparam logic [3:0] OP_MSUB  = 4'd5;
    localparam logic [3:0] OP_MSUBU = 4'd6;
    localparam logic [3:0] OP_DIV   = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    // Controller states; busy is simply "not idle".
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Special-case result patterns, wide enough for any supported WIDTH;
    // the top slices off the low WIDTH bits.
    localparam int               MAX_W       = 128;
    localparam logic [MAX_W-1:0] DIVZ_LO_PAT = '1;   // quotient on divide-by-zero
    localparam logic [MAX_W-1:0] OVF_HI_PAT  = '0;   // remainder on MIN / -1

    // Multiply-class ops share the MUL state and the product register.
    function automatic logic is_mul_op(input logic [3:0] o);
        return (o == OP_MULT)  || (o == OP_MULTU) || (o == OP_MADD) ||
               (o == OP_MADDU) || (o == OP_MSUB)  || (o == OP_MSUBU);
    endfunction

    // Ops that interpret their operands as two's complement.
    function automatic logic is_signed_op(input logic [3:0] o);
        return (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Bit-serial restoring divider datapath: one shift-subtract step per cycle
// on unsigned magnitudes. Sign handling and sequencing live in the top.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Trial subtract of the divisor from the remainder with the next dividend bit shifted in.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        fits    = ~diff[WIDTH];
    end

    // Quotient register doubles as the dividend shifter; restore on a failed subtract.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            quo <= {quo[WIDTH-2:0], fits};
            rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// HI/LO multiply-divide unit for the EX stage: fixed-latency multiply/MAC,
// iterative restoring divide, MTHI/MTLO, cancel and done pulse.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int CNT_W   = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = '1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               q_neg;
    logic               r_neg;
    logic               divz;
    logic               ovf;
    logic [WIDTH-1:0]   a_raw;

    logic               op_signed;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod_now;
    logic [2*WIDTH-1:0] mul_res;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               accept;
    logic               div_load;
    logic               div_step;

    assign busy = (state != ST_IDLE);

    // A start is only taken from idle and only when not killed the same cycle.
    assign accept   = (state == ST_IDLE) && start && !cancel;
    assign div_load = accept && ((op == OP_DIV) || (op == OP_DIVU));
    assign div_step = (state == ST_DIV) && !cancel;

    // Full-width product at issue time; sign/zero extension to 2*WIDTH makes
    // the truncated unsigned multiply correct for both signednesses.
    always_comb begin
        op_signed = is_signed_op(op);
        ext_a     = op_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
        ext_b     = op_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
        prod_now  = ext_a * ext_b;
    end

    // Divider operand magnitudes and the signs needed for the fix-up step.
    always_comb begin
        a_neg = (op == OP_DIV) && src_a[WIDTH-1];
        b_neg = (op == OP_DIV) && src_b[WIDTH-1];
        abs_a = a_neg ? (~src_a + 1'b1) : src_a;
        abs_b = b_neg ? (~src_b + 1'b1) : src_b;
    end

    // Completion values: accumulate against {HI,LO} as they stand at the write edge.
    always_comb begin
        case (op_q)
            OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod_q;
            OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod_q;
            default:           mul_res = prod_q;
        endcase
        quo_fix = q_neg ? (~quo + 1'b1) : quo;
        rem_fix = r_neg ? (~rem + 1'b1) : rem;
    end

    muldiv_div_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quo      (quo),
        .rem      (rem)
    );

    // Control FSM plus HI/LO ownership; cancel overrides any completion write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= OP_NOP;
            prod_q <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            divz   <= 1'b0;
            ovf    <= 1'b0;
            a_raw  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (op == OP_MTHI) begin
                                hi <= src_a;
                            end else if (op == OP_MTLO) begin
                                lo <= src_a;
                            end else if (is_mul_op(op)) begin
                                prod_q <= prod_now;
                                op_q   <= op;
                                cnt    <= CNT_W'(MUL_LAT - 1);
                                state  <= ST_MUL;
                            end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
                                q_neg  <= a_neg ^ b_neg;
                                r_neg  <= a_neg;
                                divz   <= (src_b == '0);
                                ovf    <= (op == OP_DIV) && (src_a == MIN_VAL) && (src_b == ALL_ONE);
                                a_raw  <= src_a;
                                op_q   <= op;
                                cnt    <= CNT_W'(WIDTH);
                                state  <= ST_DIV;
                            end
                        end
                    end
                    ST_MUL: begin
                        if (cnt == '0) begin
                            {hi, lo} <= mul_res;
                            done     <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_DIV: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        if (divz) begin
                            lo <= DIVZ_LO_PAT[WIDTH-1:0];
                            hi <= a_raw;
                        end else if (ovf) begin
                            lo <= MIN_VAL;
                            hi <= OVF_HI_PAT[WIDTH-1:0];
                        end else begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed + random bench for muldiv_iter against an arithmetic HI/LO model.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 5;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_iter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one accepted op on HI/LO.
    task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] ps, pu, acc;
        longint sa, sb, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = 64'(sa * sb);
        pu  = {32'b0, a} * {32'b0, b};
        acc = {m_hi, m_lo};
        case (o)
            OP_MULT:  {m_hi, m_lo} = ps;
            OP_MULTU: {m_hi, m_lo} = pu;
            OP_MADD:  {m_hi, m_lo} = acc + ps;
            OP_MADDU: {m_hi, m_lo} = acc + pu;
            OP_MSUB:  {m_hi, m_lo} = acc - ps;
            OP_MSUBU: {m_hi, m_lo} = acc - pu;
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    if (o == OP_DIVU) begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [3:0] o);
        if (o >= OP_MULT && o <= OP_MSUBU) return LAT;
        if (o == OP_DIV || o == OP_DIVU)   return W + 1;
        return 0;
    endfunction

    // Issue one op, watch a fixed window, then compare busy length, done count and HI/LO.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int nb, nd;
        nb = 0;
        nd = 0;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) nd++;
            @(negedge clk);
        end
        model(o, a, b);
        chk({tag, "_busy"}, 64'(nb), 64'(exp_lat(o)));
        chk({tag, "_done"}, 64'(nd), (exp_lat(o) > 0) ? 64'd1 : 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        int nd;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        reset = 1'b0; start = 1'b0; op = OP_NOP; src_a = '0; src_b = '0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        // Multiply
        run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi_k", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo_k", 64'(lo), 64'hFFFFFFFA);
        run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3);
        chk("multu_hi_k", 64'(hi), 64'h2);

        // Divide, including signed, zero and overflow cases
        run_op("divu", OP_DIVU, 32'd100, 32'd7);
        chk("divu_lo_k", 64'(lo), 64'd14);
        chk("divu_hi_k", 64'(hi), 64'd2);
        run_op("divneg", OP_DIV, 32'hFFFFFFF9, 32'd2);
        chk("divneg_lo_k", 64'(lo), 64'hFFFFFFFD);
        run_op("div0", OP_DIV, 32'd5, 32'd0);
        chk("div0_lo_k", 64'(lo), 64'hFFFFFFFF);
        run_op("divneg0", OP_DIV, 32'hFFFFFFF0, 32'd0);
        run_op("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf_lo_k", 64'(lo), 64'h80000000);
        chk("divovf_hi_k", 64'(hi), 64'h0);

        // Accumulate
        run_op("mthi0", OP_MTHI, 32'd0, 32'd0);
        run_op("mtlo1", OP_MTLO, 32'hFFFFFFFF, 32'd0);
        run_op("maddu", OP_MADDU, 32'd1, 32'd1);
        chk("maddu_hi_k", 64'(hi), 64'd1);
        run_op("msub", OP_MSUB, 32'd2, 32'd1);
        chk("msub_lo_k", 64'(lo), 64'hFFFFFFFE);

        // Cancel mid-divide at busy cycle 10
        run_op("mthiA", OP_MTHI, 32'hAAAAAAAA, 32'd0);
        run_op("mtlo5", OP_MTLO, 32'h55555555, 32'd0);
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("cxl_busy_pre", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cxl_busy", 64'(busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("cxl_done", 64'(nd), 64'd0);
        chk("cxl_hi", 64'(hi), 64'(m_hi));
        chk("cxl_lo", 64'(lo), 64'(m_lo));

        // Asynchronous reset mid-divide
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Cancel on the last multiply cycle blocks the write
        run_op("mtlo7", OP_MTLO, 32'h7, 32'd0);
        @(negedge clk);
        start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk("mcxl_busy_pre", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("mcxl_busy", 64'(busy), 64'd0);
        chk("mcxl_done", 64'(done), 64'd0);
        chk("mcxl_lo", 64'(lo), 64'(m_lo));
        chk("mcxl_hi", 64'(hi), 64'(m_hi));

        // Cancel suppresses a same-cycle start in idle
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OP_MTHI; src_a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cxs_hi", 64'(hi), 64'(m_hi));
        chk("cxs_busy", 64'(busy), 64'd0);

        // Starts while busy are ignored
        @(negedge clk);
        start = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        op = OP_MTLO; src_a = 32'h1234;
        @(negedge clk);
        op = OP_MULT; src_a = 32'd100; src_b = 32'd100;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        model(OP_MULT, 32'd3, 32'd4);
        chk("sbusy_done", 64'(nd), 64'd1);
        chk("sbusy_lo", 64'(lo), 64'(m_lo));
        chk("sbusy_hi", 64'(hi), 64'(m_hi));

        // Random ops
        for (int n = 0; n < 40; n++) begin
            ro = 4'($urandom_range(0, 11));
            if (ro == 4'd11) ro = 4'd15;
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = '1;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            run_op("rand", ro, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
